// File: rtl/regread_pkg.sv
// Shared types and sizing for the register-read stage.
package regread_pkg;

   localparam int IWD        = 4;
   localparam int WWD        = 4;
   localparam int PRFSZ      = 128;
   localparam int XLEN       = 64;
   localparam int OPID_VALID = 15;

   typedef struct packed {
      logic [15:0]      opid;
      logic [1:0][15:0] prsa;
      logic [15:0]      prda;
      logic [31:0]      imm;
   } iss_bundle_t;

   typedef struct packed {
      iss_bundle_t          iss;
      logic [1:0][XLEN-1:0] opnd;
   } rr_bundle_t;

   function automatic logic op_valid(input iss_bundle_t b);
      return b.opid[OPID_VALID];
   endfunction

endpackage

// File: rtl/regread_opnd_bypass.sv
// Operand select for one source: hardwired zero, optional writeback bypass, else PRF data.
// Writeback bypass is compiled in only when REGREAD_BYPASS_EN is defined.
module opnd_bypass
   import regread_pkg::*;
#(
   parameter int wwd  = WWD,
   parameter int pwd  = 7,
   parameter int xlen = XLEN
) (
   input  logic [pwd-1:0]            addr,
   input  logic [xlen-1:0]           prf_data,
   input  logic [wwd-1:0]            wb_val,
   input  logic [wwd-1:0][pwd-1:0]   wb_addr,
   input  logic [wwd-1:0][xlen-1:0]  wb_data,
   output logic [xlen-1:0]           operand
);

`ifdef REGREAD_BYPASS_EN
   logic hit;

   // Lowest-numbered matching writeback wins; register 0 is never bypassed.
   always_comb begin
      operand = prf_data;
      hit     = 1'b0;
      for (int j = 0; j < wwd; j++) begin
         if (!hit && wb_val[j] && (wb_addr[j] == addr)) begin
            operand = wb_data[j];
            hit     = 1'b1;
         end
      end
      if (addr == '0) begin
         operand = '0;
      end
   end
`else
   logic unused_wb;

   // PRF is write-through in this build, so writebacks need no forwarding here.
   assign unused_wb = ^{wb_val, wb_addr, wb_data};

   always_comb begin
      operand = prf_data;
      if (addr == '0) begin
         operand = '0;
      end
   end
`endif

endmodule

// File: rtl/regread.sv
// Register-read stage: accepts issued ops per slot, reads two operands each, holds them for execute.
// Optional writeback bypass inside opnd_bypass is controlled by REGREAD_BYPASS_EN.
module regread
   import regread_pkg::*;
#(
   parameter int iwd   = IWD,
   parameter int wwd   = WWD,
   parameter int prfsz = PRFSZ,
   parameter int xlen  = XLEN,
   parameter int pwd   = $clog2(prfsz)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            redir,
   input  iss_bundle_t [iwd-1:0]           iss_bundle,
   output logic [iwd-1:0]                  issue,
   output logic [iwd-1:0][1:0][pwd-1:0]    prf_raddr,
   input  logic [iwd-1:0][1:0][xlen-1:0]   prf_rdata,
   input  logic [wwd-1:0]                  wb_val,
   input  logic [wwd-1:0][pwd-1:0]         wb_addr,
   input  logic [wwd-1:0][xlen-1:0]        wb_data,
   output logic [iwd-1:0]                  rr_valid,
   output rr_bundle_t [iwd-1:0]            rr_bundle,
   input  logic [iwd-1:0]                  exe_ready
);

   logic [iwd-1:0][1:0][xlen-1:0] opnd_sel;

   // Accept must not look at iss_bundle, otherwise it loops through the issue arbiter.
   assign issue = {iwd{rst}} & (~rr_valid | exe_ready);

   for (genvar i = 0; i < iwd; i++) begin : g_slot
      for (genvar k = 0; k < 2; k++) begin : g_src
         assign prf_raddr[i][k] = iss_bundle[i].prsa[k][pwd-1:0];

         opnd_bypass #(
            .wwd  (wwd),
            .pwd  (pwd),
            .xlen (xlen)
         ) u_bypass (
            .addr     (prf_raddr[i][k]),
            .prf_data (prf_rdata[i][k]),
            .wb_val   (wb_val),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .operand  (opnd_sel[i][k])
         );
      end
   end

   // A redirect drops both the held ops and anything presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_valid  <= '0;
         rr_bundle <= '0;
      end else if (redir) begin
         rr_valid <= '0;
      end else begin
         for (int i = 0; i < iwd; i++) begin
            if (issue[i] && op_valid(iss_bundle[i])) begin
               rr_valid[i]       <= 1'b1;
               rr_bundle[i].iss  <= iss_bundle[i];
               rr_bundle[i].opnd <= opnd_sel[i];
            end else if (exe_ready[i]) begin
               rr_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_regread.sv
// Scoreboard bench for regread: stimulus pushes expected bundles, a negedge monitor pops on each handoff.
// Expectations for bypass cases follow REGREAD_BYPASS_EN.
module tb_regread;
   import regread_pkg::*;

`ifdef REGREAD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                      clk;
   logic                      rst;
   logic                      redir;
   iss_bundle_t [3:0]         iss_bundle;
   logic [3:0]                issue;
   logic [3:0][1:0][6:0]      prf_raddr;
   logic [3:0][1:0][63:0]     prf_rdata;
   logic [3:0]                wb_val;
   logic [3:0][6:0]           wb_addr;
   logic [3:0][63:0]          wb_data;
   logic [3:0]                rr_valid;
   rr_bundle_t [3:0]          rr_bundle;
   logic [3:0]                exe_ready;

   int         n_tests = 0;
   int         n_fail  = 0;
   rr_bundle_t exp_q [4][$];
   rr_bundle_t mon_exp;
   rr_bundle_t stall_exp;

   regread dut (
      .clk       (clk),
      .rst       (rst),
      .redir     (redir),
      .iss_bundle(iss_bundle),
      .issue     (issue),
      .prf_raddr (prf_raddr),
      .prf_rdata (prf_rdata),
      .wb_val    (wb_val),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .rr_valid  (rr_valid),
      .rr_bundle (rr_bundle),
      .exe_ready (exe_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic iss_bundle_t make_op(input logic [14:0] id, input logic [15:0] s0,
                                           input logic [15:0] s1, input logic [31:0] imm);
      iss_bundle_t r;
      r.opid    = {1'b1, id};
      r.prsa[0] = s0;
      r.prsa[1] = s1;
      r.prda    = {1'b0, id};
      r.imm     = imm;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Drive one op into a slot; record the bundle execute should receive if it will be captured.
   task automatic applyStimulus(input int slot, input iss_bundle_t op, input logic [63:0] d0,
                                input logic [63:0] d1, input logic [63:0] e0, input logic [63:0] e1,
                                input bit captured);
      rr_bundle_t e;
      iss_bundle[slot]   = op;
      prf_rdata[slot][0] = d0;
      prf_rdata[slot][1] = d1;
      e.iss     = op;
      e.opnd[0] = e0;
      e.opnd[1] = e1;
      if (captured) exp_q[slot].push_back(e);
   endtask

   task automatic clear_inputs();
      iss_bundle = '0;
      prf_rdata  = '0;
      wb_val     = '0;
      wb_addr    = '0;
      wb_data    = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   // Every handoff to execute must match the oldest outstanding expectation for that slot.
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            if (rr_valid[i] && exe_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("[TB] FAIL slot%0d_unexpected: got opid %h, required no op", i,
                           rr_bundle[i].iss.opid);
               end else begin
                  mon_exp = exp_q[i].pop_front();
                  checkOutput($sformatf("slot%0d_bundle", i), 256'(rr_bundle[i]), 256'(mon_exp));
               end
            end
         end
      end
   end

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: run still active at 20000, required earlier $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      redir     = 1'b0;
      exe_ready = 4'b1111;
      clear_inputs();
      for (int i = 0; i < 4; i++) iss_bundle[i] = make_op(15'(16'h100 + i), 16'd1, 16'd2, 32'h0);

      repeat (2) begin
         @(negedge clk);
         checkOutput("reset_rr_valid", 256'(rr_valid), 256'(4'b0000));
         checkOutput("reset_issue", 256'(issue), 256'(4'b0000));
      end
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("reset_bundle%0d", i), 256'(rr_bundle[i]), 256'(0));

      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      checkOutput("release_issue", 256'(issue), 256'(4'b1111));
      checkOutput("release_rr_valid", 256'(rr_valid), 256'(4'b0000));

      applyStimulus(0, make_op(15'h001, 16'd5, 16'd9, 32'hCAFE0001), 64'h11, 64'h22, 64'h11, 64'h22, 1'b1);
      next_cycle();
      @(negedge clk);
      checkOutput("basic_rr_valid", 256'(rr_valid), 256'(4'b0001));

      // Slot 2 is a gap; slot 1 has an out-of-range upper prsa bit pattern on source 1.
      wb_val     = 4'b1110;
      wb_addr[1] = 7'd12;  wb_data[1] = 64'hCC;
      wb_addr[2] = 7'd7;   wb_data[2] = 64'hBB;
      wb_addr[3] = 7'd12;  wb_data[3] = 64'hDD;
      applyStimulus(1, make_op(15'h002, 16'd7, 16'hFF83, 32'h2), 64'hAA, 64'h33,
                    BYP ? 64'hBB : 64'hAA, 64'h33, 1'b1);
      applyStimulus(3, make_op(15'h003, 16'd12, 16'd5, 32'h3), 64'h44, 64'h45,
                    BYP ? 64'hCC : 64'h44, 64'h45, 1'b1);
      #1;
      checkOutput("raddr_s1_k0", 256'(prf_raddr[1][0]), 256'(7'd7));
      checkOutput("raddr_s1_k1_upper", 256'(prf_raddr[1][1]), 256'(7'd3));
      checkOutput("raddr_s3_k0", 256'(prf_raddr[3][0]), 256'(7'd12));
      next_cycle();
      @(negedge clk);
      checkOutput("bypass_rr_valid", 256'(rr_valid), 256'(4'b1010));

      wb_val     = 4'b0001;
      wb_addr[0] = 7'd0;
      wb_data[0] = 64'hFF;
      applyStimulus(2, make_op(15'h004, 16'd0, 16'd0, 32'h4), 64'h55, 64'h66, 64'h0, 64'h0, 1'b1);
      applyStimulus(0, make_op(15'h005, 16'd0, 16'd4, 32'h5), 64'h70, 64'h77, 64'h0, 64'h77, 1'b1);
      next_cycle();
      @(negedge clk);
      checkOutput("zero_rr_valid", 256'(rr_valid), 256'(4'b0101));

      applyStimulus(2, make_op(15'h006, 16'd3, 16'd4, 32'h6), 64'h301, 64'h302, 64'h301, 64'h302, 1'b1);
      stall_exp.iss     = make_op(15'h006, 16'd3, 16'd4, 32'h6);
      stall_exp.opnd[0] = 64'h301;
      stall_exp.opnd[1] = 64'h302;
      next_cycle();
      exe_ready[2] = 1'b0;
      applyStimulus(2, make_op(15'h007, 16'd8, 16'd10, 32'h7), 64'h801, 64'h802, 64'h801, 64'h802, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("stall%0d_issue2", c), 256'(issue[2]), 256'(1'b0));
         checkOutput($sformatf("stall%0d_valid2", c), 256'(rr_valid[2]), 256'(1'b1));
         checkOutput($sformatf("stall%0d_bundle2", c), 256'(rr_bundle[2]), 256'(stall_exp));
      end
      @(posedge clk);
      #1;
      exe_ready[2] = 1'b1;
      #1;
      checkOutput("unstall_issue2", 256'(issue[2]), 256'(1'b1));
      next_cycle();
      @(negedge clk);
      checkOutput("backtoback_valid2", 256'(rr_valid[2]), 256'(1'b1));

      @(posedge clk);
      #1;
      exe_ready = 4'b1010;
      applyStimulus(0, make_op(15'h010, 16'd1, 16'd2, 32'h10), 64'h1, 64'h2, 64'h1, 64'h2, 1'b0);
      applyStimulus(2, make_op(15'h012, 16'd1, 16'd2, 32'h12), 64'h1, 64'h2, 64'h1, 64'h2, 1'b0);
      next_cycle();
      @(negedge clk);
      checkOutput("preredir_rr_valid", 256'(rr_valid), 256'(4'b0101));
      redir = 1'b1;
      for (int i = 0; i < 4; i++)
         applyStimulus(i, make_op(15'(16'h20 + i), 16'd3, 16'd4, 32'h20), 64'h3, 64'h4, 64'h3, 64'h4, 1'b0);
      #1;
      checkOutput("redir_issue", 256'(issue), 256'(4'b1010));
      next_cycle();
      redir = 1'b0;
      @(negedge clk);
      checkOutput("redir_rr_valid", 256'(rr_valid), 256'(4'b0000));

      exe_ready = 4'b1101;
      applyStimulus(1, make_op(15'h030, 16'd6, 16'd7, 32'h30), 64'h6, 64'h7, 64'h6, 64'h7, 1'b0);
      next_cycle();
      @(negedge clk);
      checkOutput("midstall_rr_valid", 256'(rr_valid), 256'(4'b0010));
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_rr_valid", 256'(rr_valid), 256'(4'b0000));
      checkOutput("midreset_issue", 256'(issue), 256'(4'b0000));
      rst       = 1'b1;
      exe_ready = 4'b1111;
      @(negedge clk);
      checkOutput("postreset_rr_valid", 256'(rr_valid), 256'(4'b0000));
      checkOutput("postreset_issue", 256'(issue), 256'(4'b1111));

      for (int n = 0; n < 3; n++) begin
         applyStimulus(3, make_op(15'(16'h40 + n), 16'(16'd20 + n), 16'd21, 32'h40),
                       64'(64'h400 + n), 64'h421, 64'(64'h400 + n), 64'h421, 1'b1);
         next_cycle();
         @(negedge clk);
         checkOutput($sformatf("thru%0d_valid3", n), 256'(rr_valid[3]), 256'(1'b1));
      end

      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("slot%0d_drained", i), 256'(exp_q[i].size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
